// File: rtl/rc5_pkg.sv
// Shared types for the rc5 CBC sequencer.
// Block/key/round widths and the controller state encoding.
package rc5_pkg;

  localparam int BLK_W = 32;
  localparam int KEY_W = 128;
  localparam int RND_W = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_PULSE = 3'd1,
    KEY_WAIT  = 3'd2,
    ISSUE     = 3'd3,
    WAIT_LO   = 3'd4,
    WAIT_HI   = 3'd5,
    OUT       = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/rc5_cbc_xor.sv
// CBC datapath: pre-core XOR, post-core XOR and chain-next select.
// In: cbc, dec, blk, chain, d_out. Out: pre, post, chain_nxt.
module rc5_cbc_xor #(
  parameter int W = rc5_pkg::BLK_W
) (
  input  logic         cbc,
  input  logic         dec,
  input  logic [W-1:0] blk,
  input  logic [W-1:0] chain,
  input  logic [W-1:0] d_out,
  output logic [W-1:0] pre,
  output logic [W-1:0] post,
  output logic [W-1:0] chain_nxt
);

  always_comb begin
    pre       = blk;
    post      = d_out;
    chain_nxt = chain;
    if (cbc) begin
      if (dec) begin
        post      = d_out ^ chain;
        chain_nxt = blk;
      end else begin
        pre       = blk ^ chain;
        chain_nxt = d_out;
      end
    end
  end

endmodule

// File: rtl/rc5_cbc_ctrl.sv
// Sequencer in front of the rc5 core: key loads, ECB/CBC blocks,
// one op in flight, valid/ready in and out.
// Ports: clk, rst (async, active-low); cfg_* config; key_req/key_busy;
// iv_load/iv_in; s_* input stream; m_* output stream; core_* to core.
// Option RC5_CTRL_WATCHDOG_EN adds a wait-state watchdog and the
// sticky err_timeout output.
module rc5_cbc_ctrl #(
  parameter int BLK_W       = rc5_pkg::BLK_W,
  parameter int KEY_W       = rc5_pkg::KEY_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [rc5_pkg::RND_W-1:0] cfg_rounds,
  input  logic [KEY_W-1:0]          cfg_key,
  input  logic                      cfg_cbc,
  input  logic                      cfg_dec,
  input  logic                      key_req,
  output logic                      key_busy,
  input  logic                      iv_load,
  input  logic [BLK_W-1:0]          iv_in,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [BLK_W-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BLK_W-1:0]          m_data,
  output logic                      core_load_key,
  input  logic                      core_key_ready,
  output logic                      core_start_enc,
  output logic                      core_start_dec,
  output logic [BLK_W-1:0]          core_d_in,
  input  logic [BLK_W-1:0]          core_d_out,
  input  logic                      core_done,
`ifdef RC5_CTRL_WATCHDOG_EN
  output logic                      err_timeout,
`endif
  output logic [rc5_pkg::RND_W-1:0] core_num_rounds,
  output logic [KEY_W-1:0]          core_key
);

  import rc5_pkg::*;

  ctrl_state_t state;
  ctrl_state_t state_d;

  logic             up_q;
  logic             cbc_q;
  logic             dec_q;
  logic [BLK_W-1:0] blk_q;
  logic [BLK_W-1:0] chain_q;
  logic [BLK_W-1:0] pre;
  logic [BLK_W-1:0] post;
  logic [BLK_W-1:0] chain_nxt;

  logic idle;
  logic s_acc;
  logic key_acc;
  logic capture;

  assign core_num_rounds = cfg_rounds;
  assign core_key        = cfg_key;

  assign idle    = (state == IDLE);
  // up_q holds s_ready low in the first cycle after reset release
  assign s_ready = up_q & idle & ~iv_load & ~key_req;
  assign s_acc   = s_valid & s_ready;
  assign key_acc = idle & ~iv_load & key_req;
  assign capture = (state == WAIT_HI) & core_done;

  assign key_busy      = (state == KEY_PULSE) | (state == KEY_WAIT);
  assign core_load_key = (state == KEY_PULSE);

  rc5_cbc_xor #(
    .W(BLK_W)
  ) u_xor (
    .cbc      (cbc_q),
    .dec      (dec_q),
    .blk      (blk_q),
    .chain    (chain_q),
    .d_out    (core_d_out),
    .pre      (pre),
    .post     (post),
    .chain_nxt(chain_nxt)
  );

`ifdef RC5_CTRL_WATCHDOG_EN
  localparam logic [9:0] WD_LIM = 10'(TIMEOUT_CYC);

  logic [9:0] wd_q;
  logic       waiting;
  logic       timeout;

  assign waiting = state inside {KEY_WAIT, WAIT_LO, WAIT_HI};
`endif

  always_comb begin
    state_d = state;
`ifdef RC5_CTRL_WATCHDOG_EN
    timeout = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (key_acc)
          state_d = KEY_PULSE;
        else if (s_acc)
          state_d = ISSUE;
      end
      KEY_PULSE: state_d = KEY_WAIT;
      KEY_WAIT: begin
        if (core_key_ready)
          state_d = IDLE;
      end
      ISSUE: state_d = WAIT_LO;
      // a done level left high by the previous block must drop first
      WAIT_LO: begin
        if (!core_done)
          state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (core_done)
          state_d = OUT;
      end
      OUT: begin
        if (m_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef RC5_CTRL_WATCHDOG_EN
    // progress in the same cycle wins over the timeout
    if (waiting && wd_q == WD_LIM && state_d == state) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      up_q           <= 1'b0;
      cbc_q          <= 1'b0;
      dec_q          <= 1'b0;
      blk_q          <= '0;
      chain_q        <= '0;
      core_d_in      <= '0;
      core_start_enc <= 1'b0;
      core_start_dec <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
    end else begin
      state          <= state_d;
      up_q           <= 1'b1;
      core_start_enc <= 1'b0;
      core_start_dec <= 1'b0;
      if (idle && iv_load)
        chain_q <= iv_in;
      if (s_acc) begin
        blk_q <= s_data;
        cbc_q <= cfg_cbc;
        dec_q <= cfg_dec;
      end
      if (state == ISSUE) begin
        core_d_in      <= pre;
        core_start_enc <= ~dec_q;
        core_start_dec <= dec_q;
      end
      if (capture) begin
        m_data  <= post;
        chain_q <= chain_nxt;
        m_valid <= 1'b1;
      end else if (state == OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef RC5_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_d != state || !waiting)
        wd_q <= '0;
      else
        wd_q <= wd_q + 10'd1;
      if (timeout)
        err_timeout <= 1'b1;
      else if (key_acc)
        err_timeout <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rc5_cbc_ctrl.sv
// Bench for rc5_cbc_ctrl: stub core plus a block-level CBC/ECB model.
// Directed cases first, then randomized traffic.
module tb_rc5_cbc_ctrl;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   cfg_rounds = 5'd12;
  logic [127:0] cfg_key = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  logic         cfg_cbc = 1'b0;
  logic         cfg_dec = 1'b0;
  logic         key_req = 1'b0;
  logic         key_busy;
  logic         iv_load = 1'b0;
  logic [31:0]  iv_in = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         core_load_key;
  logic         core_key_ready;
  logic         core_start_enc;
  logic         core_start_dec;
  logic [31:0]  core_d_in;
  logic [31:0]  core_d_out;
  logic         core_done;
  logic [4:0]   core_num_rounds;
  logic [127:0] core_key;
`ifdef RC5_CTRL_WATCHDOG_EN
  logic         err_timeout;
`endif

  always #5 clk = ~clk;

  rc5_cbc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_rounds     (cfg_rounds),
    .cfg_key        (cfg_key),
    .cfg_cbc        (cfg_cbc),
    .cfg_dec        (cfg_dec),
    .key_req        (key_req),
    .key_busy       (key_busy),
    .iv_load        (iv_load),
    .iv_in          (iv_in),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .core_load_key  (core_load_key),
    .core_key_ready (core_key_ready),
    .core_start_enc (core_start_enc),
    .core_start_dec (core_start_dec),
    .core_d_in      (core_d_in),
    .core_d_out     (core_d_out),
    .core_done      (core_done),
`ifdef RC5_CTRL_WATCHDOG_EN
    .err_timeout    (err_timeout),
`endif
    .core_num_rounds(core_num_rounds),
    .core_key       (core_key)
  );

  // stub core: d_out = d_in ^ ONES three cycles after start,
  // done held high until the next start
  logic [31:0] pend;
  int          cc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_done  <= 1'b0;
      core_d_out <= '0;
      pend       <= '0;
      cc         <= 0;
    end else if (core_start_enc | core_start_dec) begin
      core_done <= 1'b0;
      pend      <= core_d_in ^ ONES;
      cc        <= 3;
    end else if (cc != 0) begin
      cc <= cc - 1;
      if (cc == 1) begin
        core_done  <= 1'b1;
        core_d_out <= pend;
      end
    end
  end

  // stub key schedule: key_ready two cycles after load_key
  int kc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_key_ready <= 1'b0;
      kc             <= 0;
    end else if (core_load_key) begin
      core_key_ready <= 1'b0;
      kc             <= 2;
    end else if (kc != 0) begin
      kc <= kc - 1;
      if (kc == 1)
        core_key_ready <= 1'b1;
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model at block level
  logic [31:0] m_chain = '0;
  logic [31:0] q_din[$];
  logic [31:0] q_out[$];

  function automatic void model_push(input logic [31:0] b,
                                     input bit cbc, input bit dec);
    logic [31:0] din;
    logic [31:0] ct;
    logic [31:0] res;
    if (!cbc) begin
      din = b;
      res = b ^ ONES;
    end else if (!dec) begin
      din     = b ^ m_chain;
      res     = din ^ ONES;
      m_chain = res;
    end else begin
      din     = b;
      ct      = b ^ ONES;
      res     = ct ^ m_chain;
      m_chain = b;
    end
    q_din.push_back(din);
    q_out.push_back(res);
  endfunction

  // monitor, sampled on the falling edge
  int          n_enc = 0;
  int          n_dec = 0;
  int          n_hs  = 0;
  int          n_lk  = 0;
  int          n_mv  = 0;
  logic [31:0] last_din = '0;
  logic [31:0] last_m = '0;
  logic        done_at_start = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (core_start_enc | core_start_dec) begin
      chk("start_both", core_start_enc & core_start_dec, 0);
      if (core_start_enc) n_enc++;
      if (core_start_dec) n_dec++;
      last_din      = core_d_in;
      done_at_start = core_done;
      if (q_din.size() == 0)
        chk("start_extra", core_start_enc | core_start_dec, 0);
      else
        chk("core_d_in", core_d_in, q_din.pop_front());
    end
    if (core_load_key) n_lk++;
    if (m_valid) n_mv++;
    if (pv && !pr) begin
      chk("m_valid_hold", m_valid, 1);
      chk("m_data_hold", m_data, pd);
    end
    if (m_valid && m_ready) begin
      n_hs++;
      last_m = m_data;
      if (q_out.size() == 0)
        chk("m_extra", m_valid, 0);
      else
        chk("m_data", m_data, q_out.pop_front());
    end
    pv = m_valid;
    pr = m_ready;
    pd = m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit cbc, input bit dec);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    cfg_cbc = cbc;
    cfg_dec = dec;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1);
    if (s_ready) model_push(d, cbc, dec);
    tick();
    s_valid = 1'b0;
    s_data  = $urandom;
    cfg_cbc = 1'($urandom_range(0, 1));
    cfg_dec = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(input bit bp);
    int n = 0;
    while (q_out.size() != 0 && n < 300) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("out_wait", q_out.size(), 0);
  endtask

  task automatic wait_start();
    int n  = 0;
    int s0 = n_enc + n_dec;
    while (n_enc + n_dec == s0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_wait", n_enc + n_dec - s0, 1);
  endtask

  task automatic load_iv(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("iv_idle_wait", s_ready, 1);
    tick();
    iv_load = 1'b1;
    iv_in   = v;
    tick();
    iv_load = 1'b0;
    m_chain = v;
  endtask

  task automatic key_load();
    int n   = 0;
    int lk0 = n_lk;
    key_req = 1'b1;
    @(negedge clk);
    while (!key_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_busy_rise", key_busy, 1);
    tick();
    key_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (key_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_busy_fall", key_busy, 0);
    chk("key_ready_seen", core_key_ready, 1);
    chk("load_key_pulses", n_lk - lk0, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int e0, d0, hs0, lk0, mv0, n;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_load_key", core_load_key, 0);
    chk("rst_start_enc", core_start_enc, 0);
    chk("rst_start_dec", core_start_dec, 0);
    chk("rst_d_in", core_d_in, 0);
    chk("rst_key_busy", key_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    key_load();
    chk("key_rounds", core_num_rounds, 5'd12);
    chk("key_fwd", core_key[31:0], cfg_key[31:0]);

    // ECB encrypt
    e0 = n_enc;
    d0 = n_dec;
    send(32'h1234_5678, 1'b0, 1'b0);
    wait_out(1'b0);
    chk("ecb_din", last_din, 32'h1234_5678);
    chk("ecb_m", last_m, 32'hEDCB_A987);
    chk("ecb_enc_pulses", n_enc - e0, 1);
    chk("ecb_dec_pulses", n_dec - d0, 0);

    // CBC encrypt
    load_iv(32'h0000_00FF);
    send(32'h0, 1'b1, 1'b0);
    wait_out(1'b0);
    chk("cbce1_din", last_din, 32'h0000_00FF);
    chk("cbce1_m", last_m, 32'hFFFF_FF00);
    send(32'h0, 1'b1, 1'b0);
    wait_out(1'b0);
    chk("cbce2_din", last_din, 32'hFFFF_FF00);
    chk("cbce2_m", last_m, 32'h0000_00FF);

    // CBC decrypt
    e0 = n_enc;
    d0 = n_dec;
    load_iv(32'h0000_00FF);
    send(32'hFFFF_FF00, 1'b1, 1'b1);
    wait_out(1'b0);
    chk("cbcd1_m", last_m, 32'h0);
    send(32'h0000_00FF, 1'b1, 1'b1);
    wait_out(1'b0);
    chk("cbcd2_m", last_m, 32'h0);
    chk("cbcd_dec_pulses", n_dec - d0, 2);
    chk("cbcd_enc_pulses", n_enc - e0, 0);

    // stale done and backpressure
    for (int i = 0; i < 3; i++) begin
      send(32'h1111_1111 * (i + 1), i[0], 1'b0);
      wait_start();
      chk("stale_done_at_start", done_at_start, 1);
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp_mv_rise", m_valid, 1);
      hs0 = n_hs;
      tick();
      repeat (5) tick();
      chk("bp_mv_held", m_valid, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      repeat (2) tick();
      chk("bp_one_hs", n_hs - hs0, 1);
      chk("bp_mv_drop", m_valid, 0);
    end
    chk("bp_queue", q_out.size(), 0);

    // key_req during WAIT_HI is deferred to IDLE
    lk0 = n_lk;
    send(32'h5555_AAAA, 1'b0, 1'b1);
    wait_start();
    repeat (2) @(negedge clk);
    key_req = 1'b1;
    tick();
    chk("defer_busy_mid", key_busy, 0);
    wait_out(1'b0);
    chk("defer_no_load", n_lk - lk0, 0);
    chk("defer_busy_out", key_busy, 0);
    key_load();

    // reset during WAIT_HI
    load_iv(32'hDEAD_BEEF);
    send(32'h0F0F_0F0F, 1'b1, 1'b0);
    wait_start();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    q_din.delete();
    q_out.delete();
    m_chain = '0;
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_load_key", core_load_key, 0);
    chk("arst_start_enc", core_start_enc, 0);
    chk("arst_start_dec", core_start_dec, 0);
    chk("arst_d_in", core_d_in, 0);
    chk("arst_key_busy", key_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mv0 = n_mv;
    repeat (20) tick();
    chk("arst_no_mv", n_mv - mv0, 0);
    send(32'hA5A5_0000, 1'b1, 1'b0);
    wait_out(1'b0);
    chk("arst_cbc_din", last_din, 32'hA5A5_0000);
    chk("arst_cbc_m", last_m, 32'h5A5A_FFFF);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)
        load_iv($urandom);
      else if (r == 1)
        key_load();
      send($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_out(1'b1);
    end
    repeat (3) tick();
    chk("final_in_queue", q_din.size(), 0);
    chk("final_out_queue", q_out.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
